// File: rtl/pe_mac_acc.sv
// pe_mac_acc: signed multiply-accumulate element for one dot product at a time.
// Operand pairs are accepted in ACC, multiplied at full precision, added to a
// saturating accumulator and counted. The beat flagged in_last registers the
// finished sum into the output registers and moves to HOLD, where the result
// is presented until downstream consumes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   clr        soft clear of the partial sum (ignored while holding a result)
//   in_valid   operand pair valid          in_ready   operand pair accepted
//   in_a       signed activation [DW]      in_b       signed weight [DW]
//   in_last    final term of the dot product
//   out_valid  result valid                out_ready  downstream accepts result
//   out_acc    signed result [AW]          out_sat    saturation seen (sticky)
//   out_cnt    terms accumulated [CW], saturating at all-ones
module pe_mac_acc #(
  parameter int DW = 8,
  parameter int AW = 24,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic          out_sat,
  output logic [CW-1:0] out_cnt
);

  localparam logic ST_ACC  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic                 state;
  logic signed [AW-1:0] acc;
  logic                 sat_flag;
  logic [CW-1:0]        cnt;

  logic signed [2*DW-1:0] a_ext;
  logic signed [2*DW-1:0] b_ext;
  logic signed [2*DW-1:0] prod;
  logic signed [AW:0]     prod_ext;
  logic signed [AW:0]     sum;
  logic signed [AW-1:0]   acc_nxt;
  logic                   ovf;
  logic [CW-1:0]          cnt_nxt;
  logic                   accept;

  // Overflow of an AW+1-bit sum of two AW-bit-range values shows up as the
  // top two bits disagreeing; the top bit then gives the true sign.
  function automatic logic sum_ovf(input logic signed [AW:0] s);
    return s[AW] ^ s[AW-1];
  endfunction

  function automatic logic signed [AW-1:0] sat_val(input logic signed [AW:0] s);
    if (!sum_ovf(s))
      return s[AW-1:0];
    else if (s[AW])
      return {1'b1, {(AW-1){1'b0}}};
    else
      return {1'b0, {(AW-1){1'b1}}};
  endfunction

  // Operands are sign-extended to the product width so the multiply is exact.
  assign a_ext    = {{DW{in_a[DW-1]}}, in_a};
  assign b_ext    = {{DW{in_b[DW-1]}}, in_b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
  assign sum      = {acc[AW-1], acc} + prod_ext;
  assign ovf      = sum_ovf(sum);
  assign acc_nxt  = sat_val(sum);
  assign cnt_nxt  = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  assign in_ready  = rst_n && (state == ST_ACC);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && (state == ST_ACC) && !clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_ACC;
      acc      <= '0;
      sat_flag <= 1'b0;
      cnt      <= '0;
      out_acc  <= '0;
      out_sat  <= 1'b0;
      out_cnt  <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (clr) begin
            // A beat presented alongside clr is dropped.
            acc      <= '0;
            sat_flag <= 1'b0;
            cnt      <= '0;
          end else if (accept) begin
            if (in_last) begin
              out_acc  <= acc_nxt;
              out_sat  <= sat_flag | ovf;
              out_cnt  <= cnt_nxt;
              acc      <= '0;
              sat_flag <= 1'b0;
              cnt      <= '0;
              state    <= ST_HOLD;
            end else begin
              acc      <= acc_nxt;
              sat_flag <= sat_flag | ovf;
              cnt      <= cnt_nxt;
            end
          end
        end
        default: begin
          // No bypass: the next beat is taken only after returning to ACC.
          if (out_ready)
            state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_acc.sv
module tb_pe_mac_acc;

  localparam longint ACC_MAX = 8388607;
  localparam longint ACC_MIN = -8388608;
  localparam int     CNT_MAX = 65535;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_a = '0;
  logic signed [7:0] in_b = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [23:0] out_acc;
  logic              out_sat;
  logic [15:0]       out_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: running dot product as plain integers.
  longint ref_acc = 0;
  bit     ref_sat = 0;
  int     ref_cnt = 0;
  longint held_acc;
  int     held_cnt;

  pe_mac_acc #(.DW(8), .AW(24), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_sat(out_sat), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ref_acc = 0;
    ref_sat = 0;
    ref_cnt = 0;
  endtask

  task automatic model_beat(input int a, input int b);
    ref_acc = ref_acc + longint'(a) * longint'(b);
    if (ref_acc > ACC_MAX) begin
      ref_acc = ACC_MAX;
      ref_sat = 1;
    end else if (ref_acc < ACC_MIN) begin
      ref_acc = ACC_MIN;
      ref_sat = 1;
    end
    if (ref_cnt < CNT_MAX) ref_cnt++;
  endtask

  task automatic rand_operands();
    int ra;
    int rb;
    ra = int'($urandom_range(255));
    rb = int'($urandom_range(255));
    in_a = ra[7:0];
    in_b = rb[7:0];
  endtask

  task automatic send_beat(input int a, input int b, input bit last);
    in_valid = 1'b1;
    in_a = a[7:0];
    in_b = b[7:0];
    in_last = last;
    chk("in_ready_acc", in_ready, 1);
    model_beat(a, b);
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    rand_operands();
    if (last) begin
      chk("out_valid_after_last", out_valid, 1);
      chk("out_acc", out_acc, ref_acc);
      chk("out_sat", out_sat, ref_sat);
      chk("out_cnt", out_cnt, ref_cnt);
      model_clear();
    end else begin
      chk("out_valid_mid", out_valid, 0);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    chk("out_valid_before_consume", out_valid, 1);
    chk("in_ready_hold", in_ready, 0);
    step();
    out_ready = 1'b0;
    chk("out_valid_after_consume", out_valid, 0);
    chk("in_ready_after_consume", in_ready, 1);
  endtask

  initial begin
    // Reset state.
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_cnt", out_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_first_cycle", in_ready, 1);
    step();

    // Basic three-term dot product.
    send_beat(3, 4, 0);
    send_beat(-2, 5, 0);
    send_beat(7, -1, 1);
    chk("basic_acc", out_acc, -5);
    chk("basic_cnt", out_cnt, 3);
    chk("basic_sat", out_sat, 0);
    consume();

    // Positive saturation.
    for (int i = 0; i < 600; i++) send_beat(127, 127, 0);
    send_beat(0, 0, 1);
    chk("sat_pos_acc", out_acc, ACC_MAX);
    chk("sat_pos_flag", out_sat, 1);
    chk("sat_pos_cnt", out_cnt, 601);
    consume();

    // Negative saturation.
    for (int i = 0; i < 600; i++) send_beat(-128, 127, 0);
    send_beat(0, 0, 1);
    chk("sat_neg_acc", out_acc, ACC_MIN);
    chk("sat_neg_flag", out_sat, 1);
    consume();

    // Backpressure: result held while inputs are ignored.
    send_beat(9, 9, 0);
    send_beat(-3, 2, 1);
    held_acc = out_acc;
    chk("hold_acc_value", held_acc, 75);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last = i[0];
      rand_operands();
      step();
      chk("hold_acc_stable", out_acc, held_acc);
      chk("hold_cnt_stable", out_cnt, 2);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    consume();
    send_beat(5, -6, 1);
    chk("after_hold_acc", out_acc, -30);
    chk("after_hold_cnt", out_cnt, 1);
    consume();

    // Soft clear discards partial sum and a simultaneous beat.
    send_beat(10, 10, 0);
    send_beat(10, 10, 0);
    clr = 1'b1;
    in_valid = 1'b1;
    in_a = 8'sd99;
    in_b = 8'sd99;
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    model_clear();
    send_beat(2, 3, 1);
    chk("clr_acc", out_acc, 6);
    chk("clr_cnt", out_cnt, 1);
    consume();

    // Clear while holding a result has no effect.
    send_beat(4, 4, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_hold_valid", out_valid, 1);
    chk("clr_hold_acc", out_acc, 16);
    chk("clr_hold_cnt", out_cnt, 1);
    consume();

    // Single-term products and ReLU of the result.
    send_beat(-1, -1, 1);
    chk("single_pos_acc", out_acc, 1);
    chk("single_pos_cnt", out_cnt, 1);
    chk("single_pos_relu", (out_acc > 0) ? longint'(out_acc) : 0, 1);
    consume();
    send_beat(-1, 1, 1);
    chk("single_neg_acc", out_acc, -1);
    chk("single_neg_relu", (out_acc > 0) ? longint'(out_acc) : 0, 0);
    consume();

    // Reset in ACC after two terms.
    send_beat(5, 5, 0);
    send_beat(5, 5, 0);
    rst_n = 1'b0;
    step();
    chk("rst_acc_in_ready", in_ready, 0);
    chk("rst_acc_out_valid", out_valid, 0);
    chk("rst_acc_out_acc", out_acc, 0);
    chk("rst_acc_out_cnt", out_cnt, 0);
    rst_n = 1'b1;
    model_clear();
    step();
    send_beat(1, 2, 1);
    chk("post_rst_acc", out_acc, 2);
    chk("post_rst_cnt", out_cnt, 1);

    // Reset while holding: pending result is lost.
    rst_n = 1'b0;
    out_ready = 1'b0;
    step();
    chk("rst_hold_out_valid", out_valid, 0);
    chk("rst_hold_out_acc", out_acc, 0);
    chk("rst_hold_out_sat", out_sat, 0);
    chk("rst_hold_out_cnt", out_cnt, 0);
    rst_n = 1'b1;
    step();
    send_beat(2, 2, 1);
    chk("post_rst_hold_acc", out_acc, 4);
    consume();

    // Random dot products with idle gaps and random downstream delay.
    for (int t = 0; t < 25; t++) begin
      int len;
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        int gaps;
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          rand_operands();
          step();
          chk("rand_gap_out_valid", out_valid, 0);
        end
        send_beat(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                  k == len - 1);
      end
      held_acc = out_acc;
      held_cnt = len;
      for (int d = int'($urandom_range(0, 3)); d > 0; d--) begin
        step();
        chk("rand_hold_acc", out_acc, held_acc);
        chk("rand_hold_cnt", out_cnt, held_cnt);
      end
      consume();
    end

    // Term counter saturates at all-ones.
    in_valid = 1'b1;
    in_a = '0;
    in_b = '0;
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      model_beat(0, 0);
      step();
    end
    in_valid = 1'b0;
    send_beat(1, 1, 1);
    chk("cnt_sat", out_cnt, CNT_MAX);
    chk("cnt_sat_acc", out_acc, 1);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_mac_acc.md
PE_MAC_ACC -- requirements
Module: pe_mac_acc

Interface
REQ-001 Parameter DW, default 8: signed operand width.
REQ-002 Parameter AW, default 24: signed accumulator and result width; feeds pe_relu din directly.
REQ-003 Parameter CW, default 16: term-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 clr  input  1  synchronous soft clear; discards the partial sum.
REQ-007 in_valid  input  1  operand pair valid.
REQ-008 in_ready  output  1  block accepts operand pair.
REQ-009 in_a  input  DW  signed activation.
REQ-010 in_b  input  DW  signed weight.
REQ-011 in_last  input  1  final term of the current dot product.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_acc  output  AW  signed dot-product result.
REQ-015 out_sat  output  1  saturation occurred during this dot product (sticky).
REQ-016 out_cnt  output  CW  number of terms accumulated, saturating at 2^CW-1.

Function
REQ-017 Input beat accepted when in_valid && in_ready; output beat consumed when out_valid && out_ready.
REQ-018 States: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1); no other states.
REQ-019 Product = in_a*in_b, full 2*DW signed, sign-extended to AW+1 before the add.
REQ-020 Each accepted beat: acc <= sat(acc + product), clamped to [-2^(AW-1), 2^(AW-1)-1]; on clamp set sat flag.
REQ-021 Each accepted beat increments cnt, holding at 2^CW-1.
REQ-022 Accepted beat with in_last=1: register final sum/flag/count into out_acc/out_sat/out_cnt and go ACC->HOLD; out_valid high the next cycle (latency 1 cycle from last beat).
REQ-023 Same beat with in_last=1 also zeroes the internal acc, sat flag and cnt for the next dot product.
REQ-024 HOLD: out_acc, out_sat, out_cnt stable until consumed; in_ready=0, input ignored.
REQ-025 HOLD with out_ready=1: go to ACC next cycle; no same-cycle input acceptance (no bypass).
REQ-026 Single-term dot product (in_last on first beat) legal: out_acc = in_a*in_b, out_cnt = 1.
REQ-027 clr=1 in ACC: zero acc, sat flag and cnt; any simultaneous input beat is discarded.
REQ-028 clr=1 in HOLD: no effect; pending result preserved.
REQ-029 in_valid=0 in ACC: internal state holds.

Reset
REQ-030 rst_n=0 at a clock edge: state=ACC, acc=0, sat flag=0, cnt=0, out_acc=0, out_sat=0, out_cnt=0, out_valid=0.
REQ-031 Reset takes priority over clr and over all handshakes; a pending HOLD result is lost.
REQ-032 in_ready is 0 while rst_n=0 and 1 in the first cycle after release.

Verification
REQ-033 Terms (3,4),(-2,5),(7,-1) with in_last on third, out_ready=1 -> out_valid one cycle after third beat, out_acc=-5, out_cnt=3, out_sat=0.
REQ-034 Accumulate (127,127) 600 times, then (0,0) last -> out_acc=8388607, out_sat=1; repeat with (-128,127) -> out_acc=-8388608, out_sat=1.
REQ-035 out_ready=0 for 5 cycles after result -> out_acc constant, in_ready=0, inputs presented during HOLD not accumulated; next dot product starts from 0.
REQ-036 Two terms (10,10), clr for one cycle, then (2,3) last -> out_acc=6, out_cnt=1.
REQ-037 Single beat (-1,-1) with in_last -> out_acc=1, out_cnt=1; result fed to pe_relu gives 1; (-1,1) gives out_acc=-1, pe_relu 0.
REQ-038 rst_n low for one cycle during ACC after 2 terms and during HOLD -> all outputs 0, out_valid=0, next dot product result excludes earlier terms.
